coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end stage that feeds the vending machine controller. It conditions the three raw coin-slot sensors (1, 2 and 5 rupee) and produces clean, mutually exclusive, single-cycle one_in/two_in/five_in pulses, with guaranteed spacing, for the controller FSM. Conditioning covers synchronisation, debounce, queuing of near-simultaneous coins, and jam/inhibit handling. Coins that cannot be credited are rejected back to the customer through coin_reject.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to change a debounced level (min 1).
GAP_CYCLES, 2, minimum low cycles between successive output pulses (min 1).
JAM_CYCLES, 1000, debounced-high duration at or above which a sensor is declared jammed.
CNT_W, 16, width of the debounce and jam counters; must hold JAM_CYCLES.

Ports:
clk  input  1  system clock, 100 MHz, rising edge.
reset  input  1  asynchronous, active-low reset.
one_sense  input  1  raw 1-rupee slot sensor, asynchronous, bouncy, high while a coin is in the slot.
two_sense  input  1  raw 2-rupee slot sensor, same properties.
five_sense  input  1  raw 5-rupee slot sensor, same properties.
accept_en  input  1  1 = credit coins; 0 = reject every coin.
one_in  output  1  one-cycle credit pulse, 1 rupee.
two_in  output  1  one-cycle credit pulse, 2 rupee.
five_in  output  1  one-cycle credit pulse, 5 rupee.
coin_reject  output  1  one-cycle pulse: return the coin that just passed.
coin_jam  output  1  level; high while any channel is jammed.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; synchronisers, debounced levels, counters and pending counts 0; arbiter in IDLE. Coins in flight are lost. Outputs remain 0 until the first rising clk edge after reset is released.
- Per channel:
  - 2-flop synchroniser.
  - Debounce: the debounced level takes the synchronised value once that value has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles. Any mismatch gap restarts the count.
  - Jam counter: counts cycles with debounced=1. When it reaches JAM_CYCLES, the channel's jam flag sets. The flag clears on the debounced falling edge.
- Coin event: the debounced falling edge (coin has passed the sensor). Outcome, evaluated in priority order:
  1. Jam flag set: no credit, no reject.
  2. accept_en=0 at the falling edge: coin_reject pulse on the next cycle.
  3. Pending count for the channel = 3: coin_reject pulse on the next cycle.
  4. Otherwise: the channel's 2-bit pending count increments.
- Reject collisions: several rejects in one cycle produce a single coin_reject pulse. coin_reject is a registered OR of the reject conditions in that cycle.
- Arbiter FSM:
  - IDLE: if any pending count is nonzero, select the highest-priority channel (five > two > one), decrement its count, and go to ISSUE.
  - ISSUE: the selected output is 1 for exactly this one cycle; go to GAP.
  - GAP: all credit outputs 0 for GAP_CYCLES cycles, then return to IDLE.
- Timing consequences:
  - Latency from debounced falling edge to credit pulse: 2 cycles when the arbiter is idle.
  - At most one of one_in/two_in/five_in is high in any cycle.
  - Pulse period is at least GAP_CYCLES+1.
- Increment and decrement on the same channel in the same cycle: the count is unchanged.
- accept_en dropping does not flush counts that are already pending; they are still issued.
- coin_jam = OR of the three channel jam flags. It rises in the cycle after the jam counter reaches JAM_CYCLES.
- Two channels releasing in the same cycle: both are queued, then issued in priority order separated by the gap.

Test Plan:
Use DEBOUNCE_CYCLES=4, GAP_CYCLES=2, JAM_CYCLES=20.
1. Reset: hold reset=0 with sense lines toggling → all outputs stay 0. Release reset, keep sense lines low → no pulses.
2. Clean 1-rupee coin: one_sense high for 10 cycles, then low → exactly one one_in pulse, 1 cycle wide. No reject, no jam.
3. Bounce: two_sense toggles every cycle for 3 cycles, stays high 10 cycles, toggles for 3 cycles, then settles low → exactly one two_in pulse. Glitches of 3 cycles or fewer produce nothing.
4. Simultaneous coins: one_sense and five_sense both high for 10 cycles, released in the same cycle → five_in pulse, then one_in exactly 3 cycles later. Never both high in the same cycle.
5. Jam: five_sense held high for 30 cycles → coin_jam=1 from cycle 21 after the debounced rise. On release, coin_jam returns to 0 and there is no five_in and no coin_reject.
6. Inhibit and overflow:
   - accept_en=0 with one 2-rupee coin → a single coin_reject pulse and no two_in.
   - accept_en=1 with 4 one-rupee coins queued while the arbiter is blocked → 3 one_in pulses and 1 coin_reject.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises, debounces and jam-checks three raw coin
// sensors, queues coin events and issues spaced one-cycle credit pulses.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 2,
    parameter int JAM_CYCLES      = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic one_sense,
    input  logic two_sense,
    input  logic five_sense,
    input  logic accept_en,
    output logic one_in,
    output logic two_in,
    output logic five_in,
    output logic coin_reject,
    output logic coin_jam
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} arb_state_t;

    localparam int NCH = 3;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] JAM_MAX  = CNT_W'(JAM_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    // Channel index: 0 = one rupee, 1 = two rupee, 2 = five rupee.
    logic [NCH-1:0]   sense;
    logic [NCH-1:0]   sync1, sync2, deb, deb_q, jam;
    logic [CNT_W-1:0] deb_cnt [NCH];
    logic [CNT_W-1:0] jam_cnt [NCH];
    logic [1:0]       pend    [NCH];

    logic [NCH-1:0] fall, reject_req, inc, grant;
    logic           jammed;

    arb_state_t       state;
    logic [GAP_W-1:0] gap_cnt;

    assign sense    = {five_sense, two_sense, one_sense};
    assign coin_jam = |jam;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        fall       = deb_q & ~deb;
        reject_req = '0;
        inc        = '0;
        grant      = '0;
        jammed     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            // A counter already at the limit means the coin sat on the sensor
            // for JAM_CYCLES or more, even if the sticky flag is a cycle late.
            jammed = jam[i] || (jam_cnt[i] == JAM_MAX);
            if (fall[i] && !jammed) begin
                if (!accept_en || pend[i] == 2'd3) reject_req[i] = 1'b1;
                else                               inc[i]        = 1'b1;
            end
        end
        if (state == IDLE) begin
            if      (pend[2] != 2'd0) grant = 3'b100;
            else if (pend[1] != 2'd0) grant = 3'b010;
            else if (pend[0] != 2'd0) grant = 3'b001;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    // NOTE: the per-channel arrays are a handful of flops, not RAM, so they
    // are cleared by reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1       <= '0;
            sync2       <= '0;
            deb         <= '0;
            deb_q       <= '0;
            jam         <= '0;
            coin_reject <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt[i] <= '0;
                jam_cnt[i] <= '0;
                pend[i]    <= '0;
            end
        end else begin
            sync1       <= sense;
            sync2       <= sync1;
            deb_q       <= deb;
            coin_reject <= |reject_req;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end

                if (!deb[i])                   jam_cnt[i] <= '0;
                else if (jam_cnt[i] != JAM_MAX) jam_cnt[i] <= jam_cnt[i] + CNT_W'(1);

                if (fall[i])                    jam[i] <= 1'b0;
                else if (jam_cnt[i] == JAM_MAX) jam[i] <= 1'b1;

                // Simultaneous queue and issue on one channel cancel out.
                case ({inc[i], grant[i]})
                    2'b10:   pend[i] <= pend[i] + 2'd1;
                    2'b01:   pend[i] <= pend[i] - 2'd1;
                    default: pend[i] <= pend[i];
                endcase
            end
        end
    end

    // The IDLE cycle that precedes the next grant is the last cycle of the
    // gap, so GAP holds for GAP_CYCLES-1 cycles and pulses repeat every
    // GAP_CYCLES+1 cycles under back-to-back load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            one_in  <= 1'b0;
            two_in  <= 1'b0;
            five_in <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        {five_in, two_in, one_in} <= grant;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    {five_in, two_in, one_in} <= 3'b000;
                    gap_cnt <= '0;
                    state   <= (GAP_CYCLES > 1) ? GAP : IDLE;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else                     gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus randomized
// coins, compared every cycle against an event-level reference model.
module tb_coin_acceptor;

    localparam int DEB      = 4;
    localparam int GAP      = 2;
    localparam int JAM      = 20;
    localparam int SLOW_GAP = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] sense_v = 3'b000;
    logic       accept_en = 1'b1;

    logic f_one, f_two, f_five, f_rej, f_jam;
    logic s_one, s_two, s_five, s_rej, s_jam;

    // The slow instance has a long gap so coins can pile up behind the arbiter.
    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP), .JAM_CYCLES(JAM), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .one_sense(sense_v[0]), .two_sense(sense_v[1]), .five_sense(sense_v[2]),
        .accept_en(accept_en),
        .one_in(f_one), .two_in(f_two), .five_in(f_five),
        .coin_reject(f_rej), .coin_jam(f_jam)
    );

    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(SLOW_GAP), .JAM_CYCLES(JAM), .CNT_W(16)) dut_slow (
        .clk(clk), .reset(reset),
        .one_sense(sense_v[0]), .two_sense(sense_v[1]), .five_sense(sense_v[2]),
        .accept_en(accept_en),
        .one_in(s_one), .two_in(s_two), .five_in(s_five),
        .coin_reject(s_rej), .coin_jam(s_jam)
    );

    always #5 clk = ~clk;

    // Observed vectors: {five, two, one, reject, jam}.
    logic [4:0] obs [2];
    assign obs[0] = {f_five, f_two, f_one, f_rej, f_jam};
    assign obs[1] = {s_five, s_two, s_one, s_rej, s_jam};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: debounced level from a window of raw history, jam from
    // the rise/fall times of that level, coins as integer queues, and the
    // arbiter as a simple cooldown.
    logic [DEB:0] hist   [2][3];
    logic         lvl    [2][3];
    int           rise_e [2][3];
    int           fall_e [2][3];
    int           pend   [2][3];
    int           cd     [2];
    logic [4:0]   exp_v  [2];
    int           n;

    function automatic int gap_of(input int m);
        return (m == 0) ? GAP : SLOW_GAP;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int m = 0; m < 2; m++) begin
            cd[m]    = 0;
            exp_v[m] = '0;
            for (int c = 0; c < 3; c++) begin
                hist[m][c]   = '0;
                lvl[m][c]    = 1'b0;
                rise_e[m][c] = -1000;
                fall_e[m][c] = -1000;
                pend[m][c]   = 0;
            end
        end
    endtask

    task automatic model_step(input int m, input logic [2:0] raw, input logic acc);
        logic [2:0] sel  = '0;
        logic [2:0] jexp = '0;
        logic       rej  = 1'b0;
        int         pold [3];
        int         inc  [3];
        logic       flip;
        for (int c = 0; c < 3; c++) begin
            pold[c] = pend[m][c];
            inc[c]  = 0;
            // A coin event is seen the edge after the debounced level dropped.
            if (fall_e[m][c] == n - 1) begin
                if ((n - 1) - rise_e[m][c] < JAM) begin
                    if (!acc || pold[c] == 3) rej = 1'b1;
                    else                      inc[c] = 1;
                end
            end
        end
        if (cd[m] > 0) begin
            cd[m]--;
        end else begin
            for (int c = 2; c >= 0; c--) begin
                if (sel == 3'b000 && pold[c] > 0) begin
                    sel[c] = 1'b1;
                    pend[m][c]--;
                    cd[m] = gap_of(m);
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            pend[m][c] += inc[c];
            flip = 1'b1;
            for (int k = 1; k <= DEB; k++)
                if (hist[m][c][k] == lvl[m][c]) flip = 1'b0;
            if (flip) begin
                lvl[m][c] = ~lvl[m][c];
                if (lvl[m][c]) rise_e[m][c] = n;
                else           fall_e[m][c] = n;
            end
            jexp[c] = (rise_e[m][c] >= 0) && (n >= rise_e[m][c] + JAM + 1) &&
                      ((fall_e[m][c] < rise_e[m][c]) || (n <= fall_e[m][c]));
            hist[m][c] = {hist[m][c][DEB-1:0], raw[c]};
        end
        exp_v[m] = {sel[2], sel[1], sel[0], rej, |jexp};
    endtask

    int n_one [2], n_two [2], n_five [2], n_rej [2], n_jam [2];
    int t_one, t_five;

    task automatic clear_counts();
        for (int m = 0; m < 2; m++) begin
            n_one[m] = 0; n_two[m] = 0; n_five[m] = 0; n_rej[m] = 0; n_jam[m] = 0;
        end
        t_one  = -1;
        t_five = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_step(0, sense_v, accept_en);
            model_step(1, sense_v, accept_en);
            n++;
        end
        @(negedge clk);
        check("outs_fast", obs[0], reset ? exp_v[0] : 5'b0);
        check("outs_slow", obs[1], reset ? exp_v[1] : 5'b0);
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                if (obs[m][4]) n_five[m]++;
                if (obs[m][3]) n_two[m]++;
                if (obs[m][2]) n_one[m]++;
                if (obs[m][1]) n_rej[m]++;
                if (obs[m][0]) n_jam[m]++;
            end
            if (obs[0][4]) t_five = n;
            if (obs[0][2]) t_one  = n;
        end
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic coin(input logic [2:0] mask, input int high, input int bounce);
        for (int t = 0; t < bounce; t++) begin
            sense_v = (t % 2 == 0) ? mask : 3'b000;
            tick();
        end
        sense_v = mask;
        run(high);
        for (int t = 0; t < bounce; t++) begin
            sense_v = (t % 2 == 0) ? 3'b000 : mask;
            tick();
        end
        sense_v = 3'b000;
    endtask

    initial begin
        model_reset();
        clear_counts();

        // Reset held with sensors toggling: every output must stay low.
        repeat (8) begin
            sense_v = 3'($urandom);
            tick();
        end
        sense_v = 3'b000;
        model_reset();
        reset = 1'b1;
        run(20);
        check("idle_no_pulses", n_one[0] + n_two[0] + n_five[0] + n_rej[0], 0);

        clear_counts();
        coin(3'b001, 10, 0);
        run(120);
        check("clean_one_in", n_one[0], 1);
        check("clean_no_reject", n_rej[0], 0);
        check("clean_no_jam", n_jam[0], 0);

        clear_counts();
        sense_v = 3'b001;
        run(3);
        sense_v = 3'b000;
        run(20);
        check("glitch_ignored", n_one[0], 0);

        clear_counts();
        coin(3'b010, 10, 3);
        run(120);
        check("bounce_two_in", n_two[0], 1);

        clear_counts();
        coin(3'b101, 10, 0);
        run(120);
        check("simul_five_in", n_five[0], 1);
        check("simul_one_in", n_one[0], 1);
        check("simul_spacing", t_one - t_five, 3);

        clear_counts();
        sense_v = 3'b100;
        run(30);
        sense_v = 3'b000;
        run(120);
        check("jam_seen", n_jam[0] > 0, 1);
        check("jam_no_credit", n_five[0], 0);
        check("jam_no_reject", n_rej[0], 0);
        check("jam_cleared", f_jam, 0);

        clear_counts();
        accept_en = 1'b0;
        coin(3'b010, 10, 0);
        run(20);
        accept_en = 1'b1;
        run(100);
        check("inhibit_reject", n_rej[0], 1);
        check("inhibit_no_credit", n_two[0], 0);

        // A two-rupee coin occupies the slow arbiter while four ones arrive.
        clear_counts();
        coin(3'b010, 8, 0);
        repeat (4) begin
            run(8);
            coin(3'b001, 8, 0);
        end
        run(350);
        check("ovf_fast_one_in", n_one[0], 4);
        check("ovf_fast_reject", n_rej[0], 0);
        check("ovf_slow_two_in", n_two[1], 1);
        check("ovf_slow_one_in", n_one[1], 3);
        check("ovf_slow_reject", n_rej[1], 1);

        repeat (60) begin
            logic [2:0] mask;
            int         hold [3];
            int         b, len;
            accept_en = ($urandom_range(0, 4) != 0);
            mask = 3'($urandom_range(1, 7));
            b    = $urandom_range(0, 3);
            len  = 0;
            for (int c = 0; c < 3; c++) begin
                hold[c] = $urandom_range(5, 28);
                if (hold[c] > len) len = hold[c];
            end
            for (int t = 0; t < len + 2; t++) begin
                for (int c = 0; c < 3; c++)
                    sense_v[c] = mask[c] && (t < hold[c]) && !((t < b) && (t % 2 == 1));
                tick();
            end
            sense_v = 3'b000;
            run($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                sense_v = 3'($urandom_range(1, 7));
                run($urandom_range(1, 3));
                sense_v = 3'b000;
                run(5);
            end
        end
        accept_en = 1'b1;
        run(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
